// File: rtl/apb_lsu_pkg.sv
// Shared types for the APB load/store master.
// State encoding, access size codes and response status codes.
package apb_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_PERR     = 2'd1;
    localparam logic [1:0] ST_MISALIGN = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane steering: write strobes, write data shift,
// and read extract with sign/zero extension.
module apb_lane_align #(
    parameter int DATA_WIDTH = 32,
    parameter int OFFW       = $clog2(DATA_WIDTH / 8)
) (
    input  logic [1:0]              i_size,
    input  logic [OFFW-1:0]         i_off,
    input  logic                    i_signed,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic [DATA_WIDTH/8-1:0] o_stb,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int NB = DATA_WIDTH / 8;

    int                    w_nbytes;
    int                    w_nbits;
    logic                  w_msb;
    logic [DATA_WIDTH-1:0] w_sh;

    assign o_wdata = i_wdata << (8 * i_off);
    assign w_sh    = i_rdata >> (8 * i_off);

    always_comb begin
        w_nbytes = 1 << i_size;
        o_stb    = '0;
        for (int i = 0; i < NB; i++) begin
            o_stb[i] = (i >= int'(i_off)) &&
                       (i < int'(i_off) + w_nbytes);
        end
    end

    // Access wider than the bus cannot reach here legally; clamp anyway.
    always_comb begin
        w_nbits = 8 << i_size;
        if (w_nbits > DATA_WIDTH) begin
            w_nbits = DATA_WIDTH;
        end
        w_msb   = i_signed & w_sh[w_nbits-1];
        o_rdata = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            o_rdata[i] = (i < w_nbits) ? w_sh[i] : w_msb;
        end
    end

endmodule

// File: rtl/apb_lsu_master.sv
// APB master for single load/store requests with lane alignment
// and PERR / misalignment / wait-state timeout reporting.
module apb_lsu_master
    import apb_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    APB_PCLK,
    input  logic                    APB_PRESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_status,
    output logic [ADDR_WIDTH-1:0]   APB_paddr,
    output logic [DATA_WIDTH-1:0]   APB_pdata,
    input  logic [DATA_WIDTH-1:0]   APB_prdata,
    output logic                    APB_psel,
    output logic                    APB_penable,
    output logic                    APB_pwrite,
    output logic [DATA_WIDTH/8-1:0] APB_pstb,
    input  logic                    APB_pready,
    input  logic                    APB_perr
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t                r_state;
    state_t                w_next;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [OFFW-1:0]       r_off;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pdata;
    logic [NB-1:0]         r_pstb;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_status;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_tmo;
    logic [1:0]            w_size;
    logic [OFFW-1:0]       w_off;
    logic [NB-1:0]         w_stb;
    logic [DATA_WIDTH-1:0] w_wsh;
    logic [DATA_WIDTH-1:0] w_rd;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_tmo    = (TIMEOUT != 0) && (int'(r_cnt) + 1 == TIMEOUT);

    // Write lanes use the live request; read extract uses the latched one.
    assign w_size = (r_state == S_IDLE) ? req_size : r_size;
    assign w_off  = (r_state == S_IDLE) ? req_addr[OFFW-1:0] : r_off;

    always_comb begin
        unique case (req_size)
            SZ_B:    w_misalign = 1'b0;
            SZ_H:    w_misalign = req_addr[0];
            SZ_W:    w_misalign = |req_addr[1:0];
            default: w_misalign = (DATA_WIDTH == 32) || (|req_addr[2:0]);
        endcase
    end

    apb_lane_align #(
        .DATA_WIDTH(DATA_WIDTH),
        .OFFW      (OFFW)
    ) u_align (
        .i_size  (w_size),
        .i_off   (w_off),
        .i_signed(r_signed),
        .i_wdata (req_wdata),
        .i_rdata (APB_prdata),
        .o_stb   (w_stb),
        .o_wdata (w_wsh),
        .o_rdata (w_rd)
    );

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = w_misalign ? S_RESP : S_SETUP;
                end
            end
            S_SETUP: w_next = S_ACCESS;
            S_ACCESS: begin
                if (APB_pready || w_tmo) begin
                    w_next = S_RESP;
                end
            end
            default: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            r_write  <= 1'b0;
            r_size   <= SZ_B;
            r_signed <= 1'b0;
            r_off    <= '0;
            r_paddr  <= '0;
            r_pdata  <= '0;
            r_pstb   <= '0;
            r_cnt    <= '0;
            r_status <= ST_OK;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_off    <= req_addr[OFFW-1:0];
                r_paddr  <= req_addr & ~ADDR_WIDTH'(NB - 1);
                r_pdata  <= w_wsh;
                r_pstb   <= req_write ? w_stb : '1;
                if (w_misalign) begin
                    r_status <= ST_MISALIGN;
                    r_rdata  <= '0;
                end
            end
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end
            if (r_state == S_ACCESS) begin
                if (APB_pready) begin
                    r_status <= APB_perr ? ST_PERR : ST_OK;
                    r_rdata  <= (r_write || APB_perr) ? '0 : w_rd;
                end else begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_tmo) begin
                        r_status <= ST_TIMEOUT;
                        r_rdata  <= '0;
                    end
                end
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_status  = r_status;
    assign rsp_rdata   = r_rdata;
    assign APB_psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign APB_penable = (r_state == S_ACCESS);
    assign APB_pwrite  = APB_psel & r_write;
    assign APB_paddr   = r_paddr;
    assign APB_pdata   = r_pdata;
    assign APB_pstb    = r_pstb;

endmodule
